// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit with HI/LO result registers for the
//   multi-cycle MIPS datapath. Multiply is shift-add, one multiplier bit per
//   cycle. Divide is restoring division, one quotient bit per cycle. A
//   normal operation takes WIDTH iterations plus one FINISH cycle. done is
//   high in the cycle after the HI/LO write.
//
//   Optional build macro: MULTDIV_SIGNED_EN
//     When defined, the unit adds a signed_op input. Signed operands are
//     converted to magnitudes at start and run through the unsigned
//     iteration. The sign is corrected during the FINISH write, so the
//     latency is the same as for unsigned operations.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      one-cycle request, sampled only while idle
//   op         0 = multiply, 1 = divide
//   signed_op  two's-complement operands (present only with MULTDIV_SIGNED_EN)
//   a, b       rs / rt operands, latched when start is accepted
//   busy       operation in progress
//   done       one-cycle completion pulse, HI/LO valid in that cycle
//   div_zero   sticky flag: the last divide had b == 0
//   hi_out     HI register (product high half / remainder)
//   lo_out     LO register (product low half / quotient)
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULTDIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MULT   = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               op_r;
    logic               neg_q;   // negate product / quotient at FINISH
    logic               neg_r;   // negate remainder at FINISH
    logic [WIDTH-1:0]   opd;     // multiplicand (MULT) or divisor (DIV) magnitude
    // MULT: {partial product high, multiplier shifting out}
    // DIV : {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0] acc;

    logic               sgn_in;
`ifdef MULTDIV_SIGNED_EN
    assign sgn_in = signed_op;
`else
    assign sgn_in = 1'b0;
`endif

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] mult_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // NOTE: every signal is assigned a default at the top of the block, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        a_neg     = sgn_in & a[WIDTH-1];
        b_neg     = sgn_in & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        // Shift-add: conditionally add the multiplicand to the high half,
        // then shift the whole accumulator right, keeping the carry.
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
        mult_next = {mult_sum, acc[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder
        // and subtract the divisor. A borrow (bit WIDTH set) means the
        // subtraction is discarded. The remainder is always below the
        // divisor, so the difference cannot be WIDTH+1 bits wide otherwise.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd};
        div_next  = div_diff[WIDTH]
                  ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    assign busy = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_r     <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opd      <= '0;
            acc      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        if (!op) begin
                            opd   <= a_mag;
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            state <= S_MULT;
                        end else if (b == '0) begin
                            div_zero <= 1'b1;
                            state    <= S_FINISH;
                        end else begin
                            opd   <= b_mag;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            state <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc <= mult_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) state <= S_FINISH;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) state <= S_FINISH;
                end
                default: begin  // S_FINISH
                    // A divide by zero leaves HI/LO untouched.
                    if (!div_zero) begin
                        if (op_r) begin
                            hi_out <= rem_fix;
                            lo_out <= quo_fix;
                        end else begin
                            {hi_out, lo_out} <= prod_fix;
                        end
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. Directed cases are followed by
//   randomized operations. Expected HI/LO, div_zero and latency come from a
//   plain-arithmetic reference model kept here. With MULTDIV_SIGNED_EN
//   defined, signed cases are exercised as well.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, op, sgn;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi_out, lo_out;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
`ifdef MULTDIV_SIGNED_EN
        .signed_op(sgn),
`endif
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_dz = 1'b0;
    int           m_lat = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result of one operation, computed with native arithmetic.
    task automatic model(input bit mop, input logic [W-1:0] ma, input logic [W-1:0] mb, input bit ms);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        m_dz  = 1'b0;
        m_lat = 33;
        if (!mop) begin
            if (ms) begin
                sp = longint'(signed'(ma)) * longint'(signed'(mb));
                {m_hi, m_lo} = sp;
            end else begin
                up = {32'b0, ma} * {32'b0, mb};
                {m_hi, m_lo} = up;
            end
        end else if (mb == '0) begin
            m_dz  = 1'b1;
            m_lat = 1;
        end else if (ms) begin
            if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                m_lo = 32'h8000_0000;
                m_hi = '0;
            end else begin
                sa   = signed'(ma);
                sb   = signed'(mb);
                m_lo = sa / sb;
                m_hi = sa % sb;
            end
        end else begin
            m_lo = ma / mb;
            m_hi = ma % mb;
        end
    endtask

    // Waits (bounded) for done. Checks latency, busy during the operation,
    // HI/LO holding until the write, and the final result.
    task automatic wait_done(input int n0, input logic [W-1:0] p_hi, input logic [W-1:0] p_lo,
                             input string tag);
        int n = n0;
        int busy_err = 0;
        int hold_err = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
            if (!busy) busy_err++;
            if (hi_out !== p_hi || lo_out !== p_lo) hold_err++;
        end
        check({tag, "_latency"}, n, m_lat);
        check({tag, "_busy_during"}, busy_err, 0);
        check({tag, "_hold"}, hold_err, 0);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_hi"}, hi_out, m_hi);
        check({tag, "_lo"}, lo_out, m_lo);
        check({tag, "_div_zero"}, div_zero, m_dz);
    endtask

    // Issues one operation starting from a negedge and returns at the negedge
    // of its done cycle, so consecutive calls run back to back.
    task automatic do_op(input bit mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input bit ms, input string tag);
        logic [W-1:0] p_hi = m_hi, p_lo = m_lo;
        start = 1'b1; op = mop; a = ma; b = mb; sgn = ms;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the inputs: the unit must use its latched copies.
        a = $urandom; b = $urandom; op = $urandom_range(0, 1);
        model(mop, ma, mb, ms);
        wait_done(0, p_hi, p_lo, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] p_hi, p_lo;
        logic [W-1:0] ra, rb;
        bit           rop, rs;
        int           dones;

        reset = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_hi", hi_out, '0);
        check("rst_lo", lo_out, '0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(1'b0, 32'd7, 32'd6, 1'b0, "mult_7x6");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        do_op(1'b1, 32'd100, 32'd7, 1'b0, "divu_100_7");
        // 0x22222222 * 0x80000001 = 0x11111111_22222222 preloads HI/LO
        do_op(1'b0, 32'h2222_2222, 32'h8000_0001, 1'b0, "preload");
        check("preload_hi_const", hi_out, 32'h1111_1111);
        check("preload_lo_const", lo_out, 32'h2222_2222);
        do_op(1'b1, 32'd5, 32'd0, 1'b0, "div_by_zero");
        do_op(1'b0, 32'd2, 32'd3, 1'b0, "mult_after_dz");
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_by_one");
        do_op(1'b1, 32'd3, 32'd10, 1'b0, "divu_small");

`ifdef MULTDIV_SIGNED_EN
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mult_signed_m1");
        do_op(1'b1, -32'sd100, 32'd7, 1'b1, "div_signed_m100_7");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_signed_ovf");
        do_op(1'b1, 32'd100, -32'sd7, 1'b1, "div_signed_100_m7");
`endif

        // Second start at E5 with different operands must be ignored
        p_hi = m_hi; p_lo = m_lo;
        start = 1'b1; op = 1'b0; a = 32'd12345; b = 32'd678; sgn = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        model(1'b0, 32'd12345, 32'd678, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 1'b1; a = 32'd999; b = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, p_hi, p_lo, "ignored_start");

        // Start in the done cycle is accepted (back to back)
        do_op(1'b1, 32'd1000, 32'd33, 1'b0, "b2b_div");

        // Reset at E10 of a divide aborts it
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3; sgn = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_div_zero", div_zero, 1'b0);
        check("abort_hi", hi_out, '0);
        check("abort_lo", lo_out, '0);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
`ifdef MULTDIV_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            do_op(rop, ra, rb, rs, $sformatf("rand%0d", i));
        end

        // done must be a single-cycle pulse
        @(negedge clk);
        check("done_pulse_end", done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multi-cycle MIPS datapath. Executes MULT/MULTU and DIV/DIVU and holds the HI/LO result registers.
- hi_out and lo_out feed the HI and LO inputs of the register-writeback source mux directly; MFHI/MFLO select them there.
- The control FSM issues a start pulse and stalls on busy until done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  1  0 = multiply, 1 = divide.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; HI/LO are valid in that cycle.
- div_zero  output  1  sticky flag: last divide had b == 0.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (sync, active-high): state = IDLE; busy = 0, done = 0, div_zero = 0, hi_out = 0, lo_out = 0; counter and working registers cleared.
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - On start, latch a, b and op at edge E0, clear div_zero and the counter.
  - op = 0 -> MULT. op = 1 with b != 0 -> DIV. op = 1 with b == 0 -> FINISH with div_zero = 1.
- MULT: shift-add, one bit per cycle, for WIDTH cycles (edges E1..E32), 2*WIDTH-bit accumulator. After the last iteration -> FINISH.
- DIV: restoring division, one quotient bit per cycle, for WIDTH cycles (E1..E32). After the last iteration -> FINISH.
- FINISH (one cycle):
  - Multiply writes {hi_out, lo_out} = product.
  - Divide writes lo_out = quotient, hi_out = remainder.
  - For b == 0, hi_out and lo_out keep their previous values.
  - done = 1 for exactly this cycle, then -> IDLE.
- busy = 1 in MULT, DIV and FINISH; 0 in IDLE.
- Latency from start sampled at E0:
  - Normal operation: done is high in the cycle after E33; hi_out and lo_out update on E33.
  - Divide by zero: done is high after E1.
- start is ignored while busy = 1. start in the cycle after done is accepted, giving back-to-back operations.
- Operand inputs may change after E0; latched copies are used.
- hi_out and lo_out hold between operations and change only in FINISH or on reset.
- div_zero stays set until the next accepted start or reset.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no done is produced.
- Arithmetic is unsigned in the base build. The product is the full 2*WIDTH bits, with no truncation.

Optional Feature:
- Macro: MULTDIV_SIGNED_EN.
- Defined:
  - Adds input signed_op (1 bit), latched at E0 with the operands.
  - When signed_op = 1, operands are treated as two's complement. The unit takes magnitudes, runs the unsigned iteration, then applies sign correction in FINISH with no extra cycle.
  - Product sign = sign(a) XOR sign(b).
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo_out = 0x80000000, hi_out = 0.
  - Latency is unchanged.
- Undefined: no signed_op port; all operations are unsigned.

Test Plan:
- MULT 7 * 6 -> busy high E0 to E33; done pulse after E33; hi_out = 0x00000000, lo_out = 0x0000002A; no other done pulse.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi_out = 0xFFFFFFFE, lo_out = 0x00000001. With MULTDIV_SIGNED_EN and signed_op = 1 -> hi_out = 0, lo_out = 1.
- DIV 100 / 7 -> lo_out = 14, hi_out = 2. Signed -100 / 7 -> lo_out = 0xFFFFFFF2, hi_out = 0xFFFFFFFE.
- With HI/LO preloaded to 0x11111111/0x22222222, DIV 5 / 0 -> done after E1, div_zero = 1, HI/LO unchanged. A following MULT 2 * 3 clears div_zero, giving lo_out = 6.
- Start MULT; pulse start again with different operands at E5 -> second start ignored, result matches the first operands. Start asserted in the done cycle -> accepted.
- Reset asserted at E10 of a DIV -> next cycle busy = 0, done = 0, hi_out = lo_out = 0, div_zero = 0; no done pulse follows.
